issueq_freelist: RTL and testbench
==================================

Name: issueq_freelist

Overview:
Circular free list of issue-queue entry IDs. It sits between the issue-queue freeing logic and dispatch.
- Write side: accepts up to IQ_FREEING_WIDTH freed entries per cycle from the freeing logic.
- Read side: supplies DISPATCH_WIDTH free entry IDs per cycle to dispatch.
- Signals a stall when fewer than DISPATCH_WIDTH entries remain, and reinitialises to full on a pipeline flush.

Parameters:
SIZE_ISSUEQ, 32, number of issue-queue entries (power of two)
SIZE_ISSUEQ_LOG, 5, log2(SIZE_ISSUEQ)
DISPATCH_WIDTH, 4, IDs handed out per allocation
IQ_FREEING_WIDTH, 4, freed-entry write ports per cycle

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush_i  in  1  synchronous reinitialise-to-full (exception/full flush)
dispatchReady_i  in  1  dispatch requests DISPATCH_WIDTH entries this cycle
freedEntry_i  in  iqEntryPkt[IQ_FREEING_WIDTH]  freed entries {valid, id}; valid bits may be sparse
freeEntry_o  out  iqEntryPkt[DISPATCH_WIDTH]  next free IDs at head; valid = !freeListEmpty_o
freeListEmpty_o  out  1  fewer than DISPATCH_WIDTH free IDs available
freeCount_o  out  SIZE_ISSUEQ_LOG+1  current occupancy (debug/perf)

Behaviour:
- Storage: SIZE_ISSUEQ x SIZE_ISSUEQ_LOG array; headPtr and tailPtr are SIZE_ISSUEQ_LOG bits and wrap modulo SIZE_ISSUEQ; freeCnt is SIZE_ISSUEQ_LOG+1 bits.
- Reset (async) or flush_i (sync, highest priority):
  - list[k] = k for all k
  - headPtr = 0, tailPtr = 0, freeCnt = SIZE_ISSUEQ
  - all writes and allocation in that cycle are discarded
- Outputs after reset:
  - freeEntry_o[i].id = i and valid = 1 for all i
  - freeListEmpty_o = 0, freeCount_o = SIZE_ISSUEQ
- Read:
  - freeEntry_o[i].id = list[(headPtr+i) mod SIZE_ISSUEQ], combinational from registered state; zero added latency.
  - freeListEmpty_o = (freeCnt < DISPATCH_WIDTH), combinational from freeCnt.
  - When empty, freeEntry_o[i].valid = 0 and id is don't-care.
- Allocate:
  - alloc = dispatchReady_i & !freeListEmpty_o.
  - On the clock edge, headPtr += DISPATCH_WIDTH.
  - All-or-nothing: no partial allocation.
  - dispatchReady_i while empty is ignored, with no state change.
- Free:
  - Valid freed entries are compacted in port order: port j writes list[(tailPtr + popcount(valid[0..j-1])) mod SIZE_ISSUEQ].
  - tailPtr += popcount(valid).
  - Freed IDs become readable the cycle after the write edge; there is no write-to-read bypass.
- Count: freeCnt_next = freeCnt - (alloc ? DISPATCH_WIDTH : 0) + popcount(valid).
  - Simultaneous alloc and free in one cycle are both applied.
  - Read slots are taken from pre-write state, so there is no read/write hazard: alloc only consumes entries counted in freeCnt before the edge.
- Wrap-around: pointer arithmetic is modulo SIZE_ISSUEQ; allocation and write windows may straddle index SIZE_ISSUEQ-1 -> 0.
- Overflow: freeCnt_next > SIZE_ISSUEQ is illegal (double free). Behaviour is undefined; a simulation-only assertion fires.
- Duplicate IDs in one cycle's freedEntry_i are illegal, with the same assertion.

Decomposition:
- Shared package holds:
  - iqEntryPkt {valid, id[SIZE_ISSUEQ_LOG-1:0]}
  - macros SIZE_ISSUEQ, SIZE_ISSUEQ_LOG, DISPATCH_WIDTH, IQ_FREEING_WIDTH
- One sub-module, freelist_compact: combinational prefix-popcount that maps sparse valid ports to write offsets and emits the total count.
- The storage array and pointer logic stay in issueq_freelist.

Test Plan:
- Reset, then dispatchReady_i=1 for 8 cycles with no frees (SIZE 32, DW 4):
  - cycle 0: IDs {0,1,2,3}
  - cycle 7: IDs {28..31}
  - cycle 8: freeListEmpty_o=1, freeCount_o=0
- From empty, freedEntry_i valid={1,0,1,0} with ids {9,_,17,_}:
  - next cycle freeCount_o=2, still empty
  - after two more frees {5,6}, next cycle freeEntry_o ids {9,17,5,6}, empty=0
- Steady state, freeCnt=4: alloc plus free of 4 IDs {20,21,22,23} in the same cycle:
  - next cycle freeCnt=4, freeEntry_o ids {20,21,22,23}
- Wrap: headPtr=30, tailPtr=30, freeCnt=4:
  - allocation returns list[30], list[31], list[0], list[1]
  - a write of 3 IDs lands at 30, 31, 0 and tailPtr=1
- dispatchReady_i=1 while freeCnt=3 -> headPtr unchanged, outputs invalid, freeCnt stays 3.
- flush_i=1 with freeCnt=7 and concurrent free/alloc -> next cycle freeCount_o=32, freeEntry_o ids {0,1,2,3}, concurrent ops discarded.

Source files
------------

// File: rtl/issueq_freelist_pkg.sv
// Shared types and sizing for the issue-queue free list.
// Holds the entry packet format used on both the freeing side and the dispatch side.
package issueq_freelist_pkg;

  localparam int SIZE_ISSUEQ      = 32;
  localparam int SIZE_ISSUEQ_LOG  = 5;
  localparam int DISPATCH_WIDTH   = 4;
  localparam int IQ_FREEING_WIDTH = 4;

  // Wide enough to hold a count of 0..IQ_FREEING_WIDTH freed ports.
  localparam int FREE_CNT_W = $clog2(IQ_FREEING_WIDTH + 1);

  typedef struct packed {
    logic                       valid;
    logic [SIZE_ISSUEQ_LOG-1:0] id;
  } iqEntryPkt;

endpackage

// File: rtl/freelist_compact.sv
// Prefix popcount over the freed-entry valid bits.
// Each port gets the number of valid ports below it, so sparse writes pack densely at the tail.
module freelist_compact
  import issueq_freelist_pkg::*;
(
  input  logic [IQ_FREEING_WIDTH-1:0]                 validVec,
  output logic [IQ_FREEING_WIDTH-1:0][FREE_CNT_W-1:0] offset,
  output logic [FREE_CNT_W-1:0]                       total
);

  logic [FREE_CNT_W-1:0] running;

  always_comb begin
    running = '0;
    offset  = '0;
    for (int j = 0; j < IQ_FREEING_WIDTH; j++) begin
      offset[j] = running;
      running   = running + FREE_CNT_W'(validVec[j]);
    end
    total = running;
  end

endmodule

// File: rtl/issueq_freelist.sv
// Circular free list of issue-queue entry IDs between the freeing logic and dispatch.
// Hands out DISPATCH_WIDTH IDs at the head and accepts compacted frees at the tail.
module issueq_freelist
  import issueq_freelist_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush_i,
  input  logic                                  dispatchReady_i,
  input  iqEntryPkt [IQ_FREEING_WIDTH-1:0]      freedEntry_i,
  output iqEntryPkt [DISPATCH_WIDTH-1:0]        freeEntry_o,
  output logic                                  freeListEmpty_o,
  output logic [SIZE_ISSUEQ_LOG:0]              freeCount_o
);

  localparam logic [SIZE_ISSUEQ_LOG:0]   DW_CNT   = (SIZE_ISSUEQ_LOG+1)'(DISPATCH_WIDTH);
  localparam logic [SIZE_ISSUEQ_LOG:0]   FULL_CNT = (SIZE_ISSUEQ_LOG+1)'(SIZE_ISSUEQ);
  localparam logic [SIZE_ISSUEQ_LOG-1:0] DW_PTR   = SIZE_ISSUEQ_LOG'(DISPATCH_WIDTH);

  logic [SIZE_ISSUEQ_LOG-1:0] list [SIZE_ISSUEQ];
  logic [SIZE_ISSUEQ_LOG-1:0] headPtr;
  logic [SIZE_ISSUEQ_LOG-1:0] tailPtr;
  logic [SIZE_ISSUEQ_LOG:0]   freeCnt;
  logic [SIZE_ISSUEQ_LOG:0]   freeCntNext;
  logic                       alloc;

  logic [IQ_FREEING_WIDTH-1:0]                 freedValid;
  logic [IQ_FREEING_WIDTH-1:0][FREE_CNT_W-1:0] freedOffset;
  logic [FREE_CNT_W-1:0]                       freedTotal;
  logic [SIZE_ISSUEQ_LOG-1:0]                  wrIdx [IQ_FREEING_WIDTH];
  logic [SIZE_ISSUEQ_LOG-1:0]                  rdIdx [DISPATCH_WIDTH];

  always_comb begin
    for (int j = 0; j < IQ_FREEING_WIDTH; j++) begin
      freedValid[j] = freedEntry_i[j].valid;
    end
  end

  freelist_compact u_compact (
    .validVec (freedValid),
    .offset   (freedOffset),
    .total    (freedTotal)
  );

  assign freeListEmpty_o = (freeCnt < DW_CNT);
  assign freeCount_o     = freeCnt;
  assign alloc           = dispatchReady_i & ~freeListEmpty_o;
  assign freeCntNext     = freeCnt - (alloc ? DW_CNT : '0) + (SIZE_ISSUEQ_LOG+1)'(freedTotal);

  // Head-side read window comes straight from registered state; wraps modulo SIZE_ISSUEQ.
  always_comb begin
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      rdIdx[i]             = headPtr + SIZE_ISSUEQ_LOG'(i);
      freeEntry_o[i].id    = list[rdIdx[i]];
      freeEntry_o[i].valid = ~freeListEmpty_o;
    end
  end

  always_comb begin
    for (int j = 0; j < IQ_FREEING_WIDTH; j++) begin
      wrIdx[j] = tailPtr + SIZE_ISSUEQ_LOG'(freedOffset[j]);
    end
  end

  // Reset and flush both rebuild the identity list; flush drops any same-cycle alloc or free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SIZE_ISSUEQ; k++) begin
        list[k] <= SIZE_ISSUEQ_LOG'(k);
      end
      headPtr <= '0;
      tailPtr <= '0;
      freeCnt <= FULL_CNT;
    end else if (flush_i) begin
      for (int k = 0; k < SIZE_ISSUEQ; k++) begin
        list[k] <= SIZE_ISSUEQ_LOG'(k);
      end
      headPtr <= '0;
      tailPtr <= '0;
      freeCnt <= FULL_CNT;
    end else begin
      if (alloc) begin
        headPtr <= headPtr + DW_PTR;
      end
      tailPtr <= tailPtr + SIZE_ISSUEQ_LOG'(freedTotal);
      freeCnt <= freeCntNext;
      for (int j = 0; j < IQ_FREEING_WIDTH; j++) begin
        if (freedEntry_i[j].valid) begin
          list[wrIdx[j]] <= freedEntry_i[j].id;
        end
      end
    end
  end

  logic [SIZE_ISSUEQ_LOG+1:0] cntWide;
  logic                       dupFree;

  // One extra bit so a double free shows up as > SIZE_ISSUEQ instead of wrapping.
  assign cntWide = {1'b0, freeCnt}
                 - (alloc ? (SIZE_ISSUEQ_LOG+2)'(DISPATCH_WIDTH) : '0)
                 + (SIZE_ISSUEQ_LOG+2)'(freedTotal);

  always_comb begin
    dupFree = 1'b0;
    for (int j = 0; j < IQ_FREEING_WIDTH; j++) begin
      for (int k = j + 1; k < IQ_FREEING_WIDTH; k++) begin
        if (freedEntry_i[j].valid && freedEntry_i[k].valid &&
            freedEntry_i[j].id == freedEntry_i[k].id) begin
          dupFree = 1'b1;
        end
      end
    end
  end

  noOverflow: assert property (@(posedge clk) disable iff (reset || flush_i)
                               cntWide <= (SIZE_ISSUEQ_LOG+2)'(SIZE_ISSUEQ));
  noDupFree:  assert property (@(posedge clk) disable iff (reset || flush_i) !dupFree);

endmodule

// File: tb/tb_issueq_freelist.sv
// Self-checking bench for issueq_freelist: a FIFO-queue model of free IDs checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_issueq_freelist;
  import issueq_freelist_pkg::*;

  logic      clk;
  logic      reset;
  logic      flush_i;
  logic      dispatchReady_i;
  iqEntryPkt [IQ_FREEING_WIDTH-1:0] freedEntry_i;
  iqEntryPkt [DISPATCH_WIDTH-1:0]   freeEntry_o;
  logic      freeListEmpty_o;
  logic [SIZE_ISSUEQ_LOG:0] freeCount_o;

  int total = 0;
  int bad   = 0;
  int modelQ[$];

  issueq_freelist dut (
    .clk             (clk),
    .reset           (reset),
    .flush_i         (flush_i),
    .dispatchReady_i (dispatchReady_i),
    .freedEntry_i    (freedEntry_i),
    .freeEntry_o     (freeEntry_o),
    .freeListEmpty_o (freeListEmpty_o),
    .freeCount_o     (freeCount_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic checkIds(input string name, input int e0, input int e1, input int e2, input int e3);
    int exp[4];
    exp = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s_id%0d", name, i), int'(freeEntry_o[i].id), exp[i]);
    end
    checkOutput($sformatf("%s_valid", name), int'(freeEntry_o[0].valid), 1);
  endtask

  // Drive one cycle of inputs, wait for the edge, then return 3 time units later.
  task automatic applyStimulus(input logic ready, input logic flush, input logic [3:0] vld,
                               input int id0, input int id1, input int id2, input int id3);
    int ids[4];
    ids = '{id0, id1, id2, id3};
    dispatchReady_i = ready;
    flush_i         = flush;
    for (int j = 0; j < IQ_FREEING_WIDTH; j++) begin
      freedEntry_i[j].valid = vld[j];
      freedEntry_i[j].id    = SIZE_ISSUEQ_LOG'(ids[j]);
    end
    @(posedge clk);
    #3;
    dispatchReady_i = 1'b0;
    flush_i         = 1'b0;
    freedEntry_i    = '0;
  endtask

  // Model: free IDs as an ordered FIFO; allocation pops from the front, frees append in port order.
  always @(posedge clk) begin
    if (reset || flush_i) begin
      modelQ.delete();
      for (int k = 0; k < SIZE_ISSUEQ; k++) modelQ.push_back(k);
    end else begin
      if (dispatchReady_i && modelQ.size() >= DISPATCH_WIDTH) begin
        repeat (DISPATCH_WIDTH) void'(modelQ.pop_front());
      end
      for (int j = 0; j < IQ_FREEING_WIDTH; j++) begin
        if (freedEntry_i[j].valid) modelQ.push_back(int'(freedEntry_i[j].id));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("cmpCount", int'(freeCount_o), modelQ.size());
      checkOutput("cmpEmpty", int'(freeListEmpty_o), (modelQ.size() < DISPATCH_WIDTH) ? 1 : 0);
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        checkOutput($sformatf("cmpValid%0d", i), int'(freeEntry_o[i].valid),
                    (modelQ.size() >= DISPATCH_WIDTH) ? 1 : 0);
        if (modelQ.size() >= DISPATCH_WIDTH) begin
          checkOutput($sformatf("cmpId%0d", i), int'(freeEntry_o[i].id), modelQ[i]);
        end
      end
    end
  end

  initial begin
    reset           = 1'b1;
    flush_i         = 1'b0;
    dispatchReady_i = 1'b0;
    freedEntry_i    = '0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;

    checkOutput("resetCount", int'(freeCount_o), 32);
    checkOutput("resetEmpty", int'(freeListEmpty_o), 0);
    checkIds("reset", 0, 1, 2, 3);

    // Drain the full list in 8 allocations.
    repeat (7) applyStimulus(1'b1, 1'b0, 4'b0000, 0, 0, 0, 0);
    checkIds("alloc7", 28, 29, 30, 31);
    applyStimulus(1'b1, 1'b0, 4'b0000, 0, 0, 0, 0);
    checkOutput("drainEmpty", int'(freeListEmpty_o), 1);
    checkOutput("drainCount", int'(freeCount_o), 0);

    // Sparse frees from empty.
    applyStimulus(1'b0, 1'b0, 4'b0101, 9, 0, 17, 0);
    checkOutput("sparseCount", int'(freeCount_o), 2);
    checkOutput("sparseEmpty", int'(freeListEmpty_o), 1);
    applyStimulus(1'b0, 1'b0, 4'b1010, 0, 5, 0, 6);
    checkOutput("refillEmpty", int'(freeListEmpty_o), 0);
    checkIds("refill", 9, 17, 5, 6);

    // Simultaneous alloc and free.
    applyStimulus(1'b1, 1'b0, 4'b1111, 20, 21, 22, 23);
    checkOutput("steadyCount", int'(freeCount_o), 4);
    checkIds("steady", 20, 21, 22, 23);

    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 4'b1111, 4*k, 4*k+1, 4*k+2, 4*k+3);
    end
    checkIds("steadyLoop", 16, 17, 18, 19);

    // Tail straddles 31 -> 0 with a sparse 3-entry write.
    applyStimulus(1'b0, 1'b0, 4'b0011, 10, 11, 0, 0);
    checkOutput("preWrapCount", int'(freeCount_o), 6);
    applyStimulus(1'b1, 1'b0, 4'b1101, 12, 0, 13, 14);
    checkOutput("wrapCount", int'(freeCount_o), 5);
    checkIds("wrapRead", 10, 11, 12, 13);
    applyStimulus(1'b1, 1'b0, 4'b0000, 0, 0, 0, 0);
    checkOutput("postWrapCount", int'(freeCount_o), 1);
    checkOutput("postWrapEmpty", int'(freeListEmpty_o), 1);

    // Request while only 3 remain must be ignored.
    applyStimulus(1'b0, 1'b0, 4'b0011, 15, 16, 0, 0);
    applyStimulus(1'b1, 1'b0, 4'b0000, 0, 0, 0, 0);
    checkOutput("ignoreCount", int'(freeCount_o), 3);
    checkOutput("ignoreEmpty", int'(freeListEmpty_o), 1);
    checkOutput("ignoreValid", int'(freeEntry_o[0].valid), 0);
    applyStimulus(1'b0, 1'b0, 4'b0001, 17, 0, 0, 0);
    checkIds("ignoreHead", 14, 15, 16, 17);

    // Flush with concurrent alloc and free.
    applyStimulus(1'b0, 1'b0, 4'b0111, 18, 19, 20, 0);
    checkOutput("preFlushCount", int'(freeCount_o), 7);
    applyStimulus(1'b1, 1'b1, 4'b1111, 1, 2, 3, 4);
    checkOutput("flushCount", int'(freeCount_o), 32);
    checkIds("flush", 0, 1, 2, 3);
    applyStimulus(1'b1, 1'b0, 4'b0000, 0, 0, 0, 0);
    checkOutput("postFlushCount", int'(freeCount_o), 28);
    checkIds("postFlush", 4, 5, 6, 7);
    applyStimulus(1'b0, 1'b0, 4'b1001, 0, 0, 0, 1);
    checkOutput("postFlushFree", int'(freeCount_o), 30);
    applyStimulus(1'b0, 1'b0, 4'b0000, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
